// File: rtl/final_loader_pkg.sv
// Shared widths, state encoding and helpers for the final_loader host-side loader.
// Imported by the interface, the byte packer and the top.
package final_loader_pkg;

  localparam int A_WIDTH = 8;
  localparam int D_WIDTH = 8;
  localparam int RESULT_W = 20;

  localparam int W_WIDTH = 4 * D_WIDTH;
  localparam int WA_W = A_WIDTH - 2;
  localparam int WORDS = 2 ** WA_W;

  localparam int TIMEOUT_CYCLES = 4096;
  localparam int TMR_W = 13;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_WRITE  = 3'd2,
    S_SETTLE = 3'd3,
    S_GO     = 3'd4,
    S_WAIT   = 3'd5
  } state_t;

  function automatic logic is_last_word(
    input logic [WA_W-1:0] addr
  );
    return addr == WA_W'(WORDS - 1);
  endfunction

endpackage

// File: rtl/final_loader_if.sv
// Byte stream, core memory port and core run-control bundle.
// master = loader side, slave = host/core side.
interface final_loader_if;
  import final_loader_pkg::*;

  logic [D_WIDTH-1:0]  in_data;
  logic                in_valid;
  logic                in_ready;

  logic [WA_W-1:0]     m_addr6;
  logic [W_WIDTH-1:0]  m_di32;
  logic                m_enb;
  logic                m_web;

  logic                rst_core;
  logic                go_t;
  logic                done_t;
  logic [RESULT_W-1:0] result_in;

  modport master (
    input  in_data,
    input  in_valid,
    output in_ready,
    output m_addr6,
    output m_di32,
    output m_enb,
    output m_web,
    output rst_core,
    output go_t,
    input  done_t,
    input  result_in
  );

  modport slave (
    output in_data,
    output in_valid,
    input  in_ready,
    input  m_addr6,
    input  m_di32,
    input  m_enb,
    input  m_web,
    input  rst_core,
    input  go_t,
    output done_t,
    output result_in
  );

endinterface

// File: rtl/final_byte_packer.sv
// Little-endian byte-to-word packer with a 2-bit lane counter.
// o_full flags the cycle in which the 4th byte of a word is taken.
module final_byte_packer
  import final_loader_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_clr,
  input  logic               i_take,
  input  logic [D_WIDTH-1:0] i_byte,
  output logic [W_WIDTH-1:0] o_word,
  output logic               o_full
);

  logic [1:0]         r_cnt;
  logic [W_WIDTH-1:0] r_word;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_cnt  <= 2'd0;
      r_word <= '0;
    end else if (i_take) begin
      r_word[{r_cnt, 3'b000} +: D_WIDTH] <= i_byte;
      r_cnt <= r_cnt + 2'd1;
    end
  end

  assign o_full = i_take && (r_cnt == 2'd3);
  assign o_word = r_word;

endmodule

// File: rtl/final_loader.sv
// Start-triggered job: stream-load the core memory, run the core, capture its result.
// Define LOADER_TIMEOUT_EN to add the Done_t watchdog and sticky timeout flag.
module final_loader
  import final_loader_pkg::*;
(
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_start,
  final_loader_if.master      io_bus,
  output logic [RESULT_W-1:0] o_result,
  output logic                o_result_valid,
  output logic                o_busy,
  output logic                o_err_timeout
);

  state_t r_state;
  state_t w_next;

  logic [WA_W-1:0]     r_word_cnt;
  logic [RESULT_W-1:0] r_result;
  logic                r_result_valid;

  logic                w_load;
  logic                w_take;
  logic                w_clr;
  logic                w_full;
  logic                w_done;
  logic                w_last;
  logic                w_timeout;
  logic [W_WIDTH-1:0]  w_word;

  assign w_load = (r_state == S_LOAD);
  assign w_take = w_load && io_bus.in_valid;
  assign w_clr  = (r_state == S_IDLE) && i_start;
  assign w_done = (r_state == S_WAIT) && io_bus.done_t;
  assign w_last = is_last_word(r_word_cnt);

  final_byte_packer u_packer (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_clr  (w_clr),
    .i_take (w_take),
    .i_byte (io_bus.in_data),
    .o_word (w_word),
    .o_full (w_full)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next          = r_state;
    io_bus.in_ready = 1'b0;
    io_bus.m_enb    = 1'b0;
    io_bus.m_web    = 1'b0;
    io_bus.rst_core = 1'b1;
    io_bus.go_t     = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_next = S_LOAD;
        end
      end
      S_LOAD: begin
        io_bus.in_ready = 1'b1;
        if (w_full) begin
          w_next = S_WRITE;
        end
      end
      S_WRITE: begin
        io_bus.m_enb = 1'b1;
        io_bus.m_web = 1'b1;
        w_next = w_last ? S_SETTLE : S_LOAD;
      end
      S_SETTLE: begin
        w_next = S_GO;
      end
      S_GO: begin
        io_bus.rst_core = 1'b0;
        io_bus.go_t     = 1'b1;
        w_next          = S_WAIT;
      end
      S_WAIT: begin
        io_bus.rst_core = 1'b0;
        if (w_done || w_timeout) begin
          w_next = S_IDLE;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Wraps to zero after the last word; a new Start also re-zeroes it.
  always_ff @(posedge i_clk) begin
    if (i_rst || w_clr) begin
      r_word_cnt <= '0;
    end else if (r_state == S_WRITE) begin
      r_word_cnt <= r_word_cnt + WA_W'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_result       <= '0;
      r_result_valid <= 1'b0;
    end else begin
      r_result_valid <= w_done;
      if (w_done) begin
        r_result <= io_bus.result_in;
      end
    end
  end

`ifdef LOADER_TIMEOUT_EN
  logic [TMR_W-1:0] r_tmr;
  logic             r_err;

  // r_tmr counts completed WAIT cycles; the last allowed one trips the watchdog.
  always_ff @(posedge i_clk) begin
    if (i_rst || (r_state != S_WAIT)) begin
      r_tmr <= '0;
    end else if (!io_bus.done_t) begin
      r_tmr <= r_tmr + TMR_W'(1);
    end
  end

  assign w_timeout = (r_state == S_WAIT)
                  && !io_bus.done_t
                  && (r_tmr == TMR_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge i_clk) begin
    if (i_rst || w_clr) begin
      r_err <= 1'b0;
    end else if (w_timeout) begin
      r_err <= 1'b1;
    end
  end

  assign o_err_timeout = r_err;
`else
  assign w_timeout     = 1'b0;
  assign o_err_timeout = 1'b0;
`endif

  assign io_bus.m_addr6 = r_word_cnt;
  assign io_bus.m_di32  = w_word;

  assign o_result       = r_result;
  assign o_result_valid = r_result_valid;
  assign o_busy         = (r_state != S_IDLE);

endmodule

// File: tb/tb_final_loader.sv
// Self-checking bench for final_loader: stream load, core run, abort, ignored events, watchdog.
// Expected memory images come from the byte stream by the little-endian packing rule.
module tb_final_loader;
  import final_loader_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [19:0] result;
  logic        result_valid;
  logic        busy;
  logic        err;

  final_loader_if u_if ();

  final_loader dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_start        (start),
    .io_bus         (u_if.master),
    .o_result       (result),
    .o_result_valid (result_valid),
    .o_busy         (busy),
    .o_err_timeout  (err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int start_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // observed memory and event counters, written only by the monitor
  logic [31:0] mem [64];
  int          stamp [64];
  int          wr_cnt = 0;
  int          rdy_in_wr = 0;
  int          go_cnt = 0;
  int          go_cyc = 0;
  int          rv_cnt = 0;
  int          err_cyc = -1;
  logic        err_q = 1'b0;
  int          core_timer = 0;

  // core model configuration, written only by the stimulus
  logic        core_en = 1'b0;
  logic        core_glitch = 1'b0;
  int          core_delay = 10;
  logic [19:0] core_result = '0;

  logic [7:0]  stim [$];

  always @(negedge clk) begin
    u_if.done_t = 1'b0;
    if (u_if.m_enb && u_if.m_web) begin
      mem[u_if.m_addr6] = u_if.m_di32;
      stamp[u_if.m_addr6] = wr_cnt + 1;
      wr_cnt++;
      if (u_if.in_ready) rdy_in_wr++;
    end
    if (result_valid) rv_cnt++;
    if (err && !err_q) err_cyc = cyc;
    err_q = err;
    if (core_timer > 0) begin
      core_timer--;
      if (core_timer == 0) begin
        u_if.done_t = 1'b1;
        u_if.result_in = core_result;
      end
    end
    if (u_if.go_t) begin
      go_cnt++;
      go_cyc = cyc;
      if (core_en) core_timer = core_delay;
      if (core_glitch) begin
        u_if.done_t = 1'b1;
        u_if.result_in = ~core_result;
      end
    end
  end

  function automatic logic [31:0] exp_word(input int i);
    return {stim[4*i+3], stim[4*i+2], stim[4*i+1], stim[4*i]};
  endfunction

  function automatic int image_errors(input int base);
    int e = 0;
    for (int i = 0; i < 64; i++) begin
      if (stamp[i] <= base || mem[i] !== exp_word(i)) e++;
    end
    return e;
  endfunction

  task automatic start_job();
    @(negedge clk);
    start = 1'b1;
    start_cyc = cyc;
  endtask

  task automatic feed(input int n, input bit toggle);
    int idx;
    int b;
    bit ph;
    logic rdy;
    idx = 0;
    b = 0;
    ph = 1'b0;
    while (idx < n && b < 3000) begin
      @(negedge clk);
      if (b == 0) start = 1'b0;
      b++;
      rdy = u_if.in_ready;
      ph = !ph;
      if (toggle && !ph) begin
        u_if.in_valid = 1'b0;
      end else begin
        u_if.in_valid = 1'b1;
        u_if.in_data = stim[idx];
        if (rdy) idx++;
      end
    end
    @(negedge clk);
    u_if.in_valid = 1'b0;
    n_chk++;
    if (idx !== n) begin
      n_fail++;
      $display("FAIL feed_bytes accepted %0d want %0d", idx, n);
    end
  endtask

  task automatic wait_go(input int g0, input int budget, output bit ok);
    int b = 0;
    #1;
    while (go_cnt == g0 && b < budget) begin
      @(negedge clk);
      #1;
      b++;
    end
    ok = (go_cnt != g0);
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    int b = 0;
    #1;
    while (busy && b < budget) begin
      @(negedge clk);
      #1;
      b++;
    end
    ok = !busy;
  endtask

  int b_go, b_wr, b_rv, b_rdy;
  logic [19:0] last_result;

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    u_if.in_valid = 1'b0;
    u_if.in_data = '0;
    repeat (3) @(negedge clk);
    #1;
    n_chk++;
    if ({busy, result_valid, err, u_if.in_ready} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_flags got %b want 0000", {busy, result_valid, err, u_if.in_ready});
    end
    n_chk++;
    if ({u_if.rst_core, u_if.go_t, u_if.m_enb, u_if.m_web} !== 4'b1000) begin
      n_fail++;
      $display("FAIL reset_core got %b want 1000", {u_if.rst_core, u_if.go_t, u_if.m_enb, u_if.m_web});
    end
    n_chk++;
    if (u_if.m_addr6 !== 6'd0 || u_if.m_di32 !== 32'd0 || result !== 20'd0) begin
      n_fail++;
      $display("FAIL reset_data got %h %h %h want 0", u_if.m_addr6, u_if.m_di32, result);
    end
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
    n_chk++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_wins_start busy got %b want 0", busy);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_load_seq();
    bit ok;
    stim.delete();
    for (int i = 0; i < 256; i++) stim.push_back(8'(i));
    core_en = 1'b1;
    core_glitch = 1'b0;
    core_delay = 10;
    core_result = 20'h07F80;
    b_go = go_cnt;
    b_wr = wr_cnt;
    b_rv = rv_cnt;
    start_job();
    feed(256, 1'b0);
    wait_go(b_go, 400, ok);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL load_go_seen got none want pulse");
    end
    n_chk++;
    if (go_cyc - start_cyc !== 322) begin
      n_fail++;
      $display("FAIL load_go_latency got %0d want 322", go_cyc - start_cyc);
    end
    n_chk++;
    if (image_errors(b_wr) !== 0) begin
      n_fail++;
      $display("FAIL load_image bad_words %0d want 0", image_errors(b_wr));
    end
    n_chk++;
    if (mem[0] !== 32'h03020100 || mem[63] !== 32'hFFFEFDFC) begin
      n_fail++;
      $display("FAIL load_ends got %h %h want 03020100 fffefdfc", mem[0], mem[63]);
    end
    n_chk++;
    if (wr_cnt - b_wr !== 64) begin
      n_fail++;
      $display("FAIL load_writes got %0d want 64", wr_cnt - b_wr);
    end
  endtask

  task automatic test_core_done();
    bit ok;
    wait_idle(100, ok);
    n_chk++;
    if (!ok || u_if.rst_core !== 1'b1) begin
      n_fail++;
      $display("FAIL done_idle busy %b rst_core %b want 0 1", busy, u_if.rst_core);
    end
    n_chk++;
    if (result !== 20'h07F80) begin
      n_fail++;
      $display("FAIL done_result got %h want 07f80", result);
    end
    repeat (3) @(negedge clk);
    #1;
    n_chk++;
    if (rv_cnt - b_rv !== 1) begin
      n_fail++;
      $display("FAIL done_valid_cycles got %0d want 1", rv_cnt - b_rv);
    end
    n_chk++;
    if (go_cnt - b_go !== 1) begin
      n_fail++;
      $display("FAIL go_cycles got %0d want 1", go_cnt - b_go);
    end
    last_result = result;
  endtask

  task automatic test_valid_toggle();
    bit ok;
    stim.delete();
    for (int i = 0; i < 256; i++) stim.push_back(8'(i));
    core_delay = $urandom_range(3, 20);
    core_result = 20'($urandom);
    b_go = go_cnt;
    b_wr = wr_cnt;
    b_rv = rv_cnt;
    b_rdy = rdy_in_wr;
    start_job();
    feed(256, 1'b1);
    wait_go(b_go, 400, ok);
    wait_idle(100, ok);
    n_chk++;
    if (!ok || image_errors(b_wr) !== 0 || wr_cnt - b_wr !== 64) begin
      n_fail++;
      $display("FAIL toggle_image bad_words %0d writes %0d want 0 64", image_errors(b_wr), wr_cnt - b_wr);
    end
    n_chk++;
    if (rdy_in_wr - b_rdy !== 0) begin
      n_fail++;
      $display("FAIL toggle_ready_in_write got %0d want 0", rdy_in_wr - b_rdy);
    end
    n_chk++;
    if (result !== core_result || rv_cnt - b_rv !== 1) begin
      n_fail++;
      $display("FAIL toggle_result got %h/%0d want %h/1", result, rv_cnt - b_rv, core_result);
    end
    last_result = result;
  endtask

  task automatic test_abort_reload();
    bit ok;
    stim.delete();
    for (int i = 0; i < 256; i++) stim.push_back(8'($urandom));
    core_delay = $urandom_range(3, 20);
    core_result = 20'($urandom);
    b_go = go_cnt;
    start_job();
    feed(100, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    #1;
    n_chk++;
    if (busy !== 1'b0 || u_if.rst_core !== 1'b1 || u_if.m_addr6 !== 6'd0 || u_if.in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_state busy %b rst_core %b addr %0d rdy %b want 0 1 0 0",
               busy, u_if.rst_core, u_if.m_addr6, u_if.in_ready);
    end
    rst = 1'b0;
    stim.delete();
    for (int i = 0; i < 256; i++) stim.push_back(8'hA5);
    b_wr = wr_cnt;
    b_rv = rv_cnt;
    start_job();
    feed(256, 1'b0);
    wait_go(b_go, 400, ok);
    n_chk++;
    if (!ok || go_cyc - start_cyc !== 322 || go_cnt - b_go !== 1) begin
      n_fail++;
      $display("FAIL reload_go latency %0d pulses %0d want 322 1", go_cyc - start_cyc, go_cnt - b_go);
    end
    wait_idle(100, ok);
    n_chk++;
    if (image_errors(b_wr) !== 0 || mem[17] !== 32'hA5A5A5A5) begin
      n_fail++;
      $display("FAIL reload_image bad_words %0d word17 %h want 0 a5a5a5a5", image_errors(b_wr), mem[17]);
    end
    n_chk++;
    if (!ok || result !== core_result) begin
      n_fail++;
      $display("FAIL reload_result got %h want %h", result, core_result);
    end
    last_result = result;
  endtask

  task automatic test_ignored_events();
    bit ok;
    stim.delete();
    for (int i = 0; i < 256; i++) stim.push_back(8'($urandom));
    core_delay = $urandom_range(3, 20);
    core_result = 20'($urandom);
    core_glitch = 1'b1;
    b_go = go_cnt;
    b_wr = wr_cnt;
    b_rv = rv_cnt;
    start_job();
    fork
      feed(256, 1'b0);
      begin
        repeat (50 + $urandom_range(0, 7)) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
    join
    wait_go(b_go, 400, ok);
    n_chk++;
    if (!ok || go_cyc - start_cyc !== 322) begin
      n_fail++;
      $display("FAIL ignore_go_latency got %0d want 322", go_cyc - start_cyc);
    end
    wait_idle(100, ok);
    repeat (2) @(negedge clk);
    #1;
    core_glitch = 1'b0;
    n_chk++;
    if (image_errors(b_wr) !== 0) begin
      n_fail++;
      $display("FAIL ignore_image bad_words %0d want 0", image_errors(b_wr));
    end
    n_chk++;
    if (!ok || result !== core_result || rv_cnt - b_rv !== 1) begin
      n_fail++;
      $display("FAIL ignore_result got %h/%0d want %h/1", result, rv_cnt - b_rv, core_result);
    end
    last_result = result;
  endtask

  task automatic test_timeout();
    bit ok;
    stim.delete();
    for (int i = 0; i < 256; i++) stim.push_back(8'($urandom));
    core_en = 1'b0;
    b_go = go_cnt;
    b_rv = rv_cnt;
    start_job();
    feed(256, 1'b0);
    wait_go(b_go, 400, ok);
`ifdef LOADER_TIMEOUT_EN
    wait_idle(4200, ok);
    n_chk++;
    if (!ok || err !== 1'b1 || u_if.rst_core !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_flag busy %b err %b rst_core %b want 0 1 1", busy, err, u_if.rst_core);
    end
    n_chk++;
    if (err_cyc - go_cyc !== 4097) begin
      n_fail++;
      $display("FAIL timeout_latency got %0d want 4097", err_cyc - go_cyc);
    end
    n_chk++;
    if (rv_cnt - b_rv !== 0 || result !== last_result) begin
      n_fail++;
      $display("FAIL timeout_result got %h/%0d want %h/0", result, rv_cnt - b_rv, last_result);
    end
    start_job();
    @(negedge clk);
    start = 1'b0;
    #1;
    n_chk++;
    if (err !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_clear err %b busy %b want 0 1", err, busy);
    end
`else
    repeat (300) @(negedge clk);
    #1;
    n_chk++;
    if (busy !== 1'b1 || err !== 1'b0 || u_if.rst_core !== 1'b0) begin
      n_fail++;
      $display("FAIL wait_hold busy %b err %b rst_core %b want 1 0 0", busy, err, u_if.rst_core);
    end
    n_chk++;
    if (rv_cnt - b_rv !== 0 || result !== last_result) begin
      n_fail++;
      $display("FAIL wait_result got %h/%0d want %h/0", result, rv_cnt - b_rv, last_result);
    end
`endif
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_chk++;
    if (busy !== 1'b0 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL final_reset busy %b err %b want 0 0", busy, err);
    end
  endtask

  initial begin
    test_reset();
    test_load_seq();
    test_core_done();
    test_valid_toggle();
    test_abort_reload();
    test_ignored_events();
    test_timeout();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
